// File: rtl/temp_history_pkg.sv
// rtl/temp_history_pkg.sv - shared temperature constants and helpers
// Purpose: temperature width and full-scale value, plus a width helper.
//          The trend history and the other temperature stages all use them.
// Ports:   none (package)
package temp_history_pkg;

    localparam int TEMP_W = 10;
    localparam logic [TEMP_W-1:0] TEMP_MAX = 10'd1000;

    // Counter width that never collapses to zero bits, so DECIM=1 stays legal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temp_history_if.sv
// rtl/temp_history_if.sv - sample-in / read-back bus of the temperature history
// Purpose: groups the sample strobe, the read-by-age port and the status outputs.
// Ports:   master drives start/temp/oor/rd_age. slave (temp_history) drives
//          rd_data/rd_hit/count/min_temp/max_temp/stored.
interface temp_history_if #(
    parameter int DEPTH = 1024
) ();
    import temp_history_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic              start;
    logic [TEMP_W-1:0] temp;
    logic              oor;
    logic [AW-1:0]     rd_age;
    logic [TEMP_W-1:0] rd_data;
    logic              rd_hit;
    logic [AW:0]       count;
    logic [TEMP_W-1:0] min_temp;
    logic [TEMP_W-1:0] max_temp;
    logic              stored;

    modport master (
        output start, temp, oor, rd_age,
        input  rd_data, rd_hit, count, min_temp, max_temp, stored
    );

    modport slave (
        input  start, temp, oor, rd_age,
        output rd_data, rd_hit, count, min_temp, max_temp, stored
    );

endinterface

// File: rtl/temp_history_ram.sv
// rtl/temp_history_ram.sv - simple dual-port RAM with registered read
// Purpose: DEPTH x WIDTH sample store that maps onto block RAM.
//          A read and a write to the same address in one cycle return the old contents.
// Ports:   clk; write port we/waddr/wdata; read port raddr -> rdata one cycle later.
module temp_history_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/temp_history.sv
// rtl/temp_history.sv - decimating circular store of filtered temperatures
// Purpose: keeps the newest DEPTH decimated samples, lets readers fetch them by
//          age with one cycle of latency, and tracks min/max of everything stored.
//          TEMP_HISTORY_AVG_EN: store the truncated mean of each DECIM group
//          instead of its last sample.
// Ports:   clk, reset (synchronous, active-high), bus (temp_history_if.slave):
//          start/temp/oor sample in, rd_age in, rd_data/rd_hit out (1-cycle latency),
//          count, min_temp, max_temp, stored pulse.
module temp_history
    import temp_history_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int DECIM = 4
) (
    input  logic          clk,
    input  logic          reset,
    temp_history_if.slave bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DSH = $clog2(DECIM);
    localparam int DW  = clog2_min1(DECIM);
    localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
    localparam logic [AW:0]   DEPTH_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [DW-1:0]     decim_cnt;
    logic [AW:0]       count_q;
    logic [TEMP_W-1:0] min_q;
    logic [TEMP_W-1:0] max_q;
    logic              stored_q;
    logic              hit_q;

    logic              accept;
    logic              group_end;
    logic              we;
    logic [TEMP_W-1:0] wdata;
    logic [AW-1:0]     raddr;
    logic [TEMP_W-1:0] ram_q;

    assign accept    = bus.start && !bus.oor;
    assign group_end = (decim_cnt == DECIM_LAST);
    assign we        = accept && group_end;

`ifdef TEMP_HISTORY_AVG_EN
    localparam int ACC_W = TEMP_W + DSH;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    // The sum includes the sample arriving now, so the group's last value
    // takes part in the mean without an extra cycle.
    assign acc_sum = acc + ACC_W'(bus.temp);
    assign wdata   = TEMP_W'(acc_sum >> DSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (we) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_sum;
        end
    end
`else
    assign wdata = bus.temp;
`endif

    // Age 0 is the slot just behind wr_ptr. Using the pre-write pointer gives
    // readers the old view when a write lands in the same cycle.
    assign raddr = wr_ptr - AW'(1) - bus.rd_age;

    temp_history_ram #(
        .DEPTH (DEPTH),
        .WIDTH (TEMP_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            decim_cnt <= '0;
            count_q   <= '0;
            min_q     <= TEMP_MAX;
            max_q     <= '0;
            stored_q  <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            stored_q <= we;
            hit_q    <= ({1'b0, bus.rd_age} < count_q);
            if (accept) begin
                decim_cnt <= group_end ? '0 : decim_cnt + DW'(1);
            end
            if (we) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count_q != DEPTH_FULL) begin
                    count_q <= count_q + (AW + 1)'(1);
                end
                if (wdata < min_q) begin
                    min_q <= wdata;
                end
                if (wdata > max_q) begin
                    max_q <= wdata;
                end
            end
        end
    end

    // RAM contents are never cleared, so a miss must force the data to zero.
    assign bus.rd_data  = hit_q ? ram_q : '0;
    assign bus.rd_hit   = hit_q;
    assign bus.count    = count_q;
    assign bus.min_temp = min_q;
    assign bus.max_temp = max_q;
    assign bus.stored   = stored_q;

endmodule
